// File: rtl/bitstream_layer_seq.sv
// bitstream_layer_seq
//   Sequenced stochastic-computing layer. Each neuron ORs its input bits, each
//   gated by a comparator SNG (16-bit Galois LFSR compared against a runtime
//   weight). A control FSM runs a window of STREAM_LEN valid input bits,
//   counts ones per neuron, then offers the counts through a valid/ready port.
//
// Ports:
//   clk, n_rst                    clock, asynchronous active-low reset
//   cfg_we/neuron/input/weight    weight bank write (accepted only while idle)
//   start, busy                   window start request, FSM not idle
//   layer_input, in_valid         input bitstream bits and their qualifier
//   stream_out, stream_valid      registered neuron bits for the next layer
//   result_data/valid/ready       per-neuron counts, neuron i at [i*CNT_W +: CNT_W]

module bitstream_layer_seq #(
  parameter int INPUT_SIZE   = 2,
  parameter int NEURON_COUNT = 2,
  parameter int WEIGHT_W     = 8,
  parameter int STREAM_LEN   = 256,
  parameter int SEED         = 0,
  parameter int CNT_W        = $clog2(STREAM_LEN + 1),
  localparam int NSEL_W      = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1,
  localparam int ISEL_W      = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cfg_we,
  input  logic [NSEL_W-1:0]             cfg_neuron,
  input  logic [ISEL_W-1:0]             cfg_input,
  input  logic [WEIGHT_W-1:0]           cfg_weight,
  input  logic                          start,
  output logic                          busy,
  input  logic [INPUT_SIZE-1:0]         layer_input,
  input  logic                          in_valid,
  output logic [NEURON_COUNT-1:0]       stream_out,
  output logic                          stream_valid,
  output logic [NEURON_COUNT*CNT_W-1:0] result_data,
  output logic                          result_valid,
  input  logic                          result_ready
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        remaining_reg;
  logic [NEURON_COUNT-1:0] neuron_bit;
  logic                    load;   // idle -> run: clear counters, reload LFSRs
  logic                    step;   // one valid input bit consumed this cycle
  logic                    wr_en;

  // Per-(neuron, input) LFSR seed; zero would lock the LFSR, so map it to 1.
  function automatic logic [15:0] seed_of(input int i, input int j);
    logic [15:0] s;
    s = 16'(SEED + i * INPUT_SIZE + j + 1);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  // Control FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    step         = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    wr_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_en = cfg_we && (32'(cfg_neuron) < NEURON_COUNT) && (32'(cfg_input) < INPUT_SIZE);
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = in_valid;
        if (in_valid && remaining_reg == CNT_W'(1)) state_next = HOLD;
      end
      HOLD: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    remaining_reg <= '0;
    else if (load) remaining_reg <= CNT_W'(STREAM_LEN);
    else if (step) remaining_reg <= remaining_reg - CNT_W'(1);
  end

  // Per-neuron datapath: weights, SNGs, OR reduction, ones counter
  genvar gi, gj;
  generate
    for (gi = 0; gi < NEURON_COUNT; gi++) begin : g_neuron
      logic [INPUT_SIZE-1:0] wbit;
      logic [CNT_W-1:0]      count_reg;

      for (gj = 0; gj < INPUT_SIZE; gj++) begin : g_input
        localparam logic [15:0] SEED_IJ = seed_of(gi, gj);
        logic [WEIGHT_W-1:0] weight_reg;
        logic [15:0]         lfsr_reg;
        logic [15:0]         lfsr_next;

        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst)
            weight_reg <= '0;
          else if (wr_en && 32'(cfg_neuron) == gi && 32'(cfg_input) == gj)
            weight_reg <= cfg_weight;
        end

        assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst)    lfsr_reg <= SEED_IJ;
          else if (load) lfsr_reg <= SEED_IJ;
          else if (step) lfsr_reg <= lfsr_next;
        end

        // All-ones weight stands for probability 1.0, which a strict
        // less-than compare could never reach.
        assign wbit[gj] = (&weight_reg) || (lfsr_reg[WEIGHT_W-1:0] < weight_reg);
      end

      assign neuron_bit[gi] = |(layer_input & wbit);

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)    count_reg <= '0;
        else if (load) count_reg <= '0;
        else if (step) count_reg <= count_reg + CNT_W'(neuron_bit[gi]);
      end

      assign result_data[gi*CNT_W +: CNT_W] = count_reg;
    end
  endgenerate

  // stream_out keeps its last value on cycles without a valid input bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stream_out   <= '0;
      stream_valid <= 1'b0;
    end else begin
      stream_valid <= step;
      if (step) stream_out <= neuron_bit;
    end
  end

endmodule

// File: doc/bitstream_layer_seq.md
Name: bitstream_layer_seq

Overview:
- Sequenced, parametrised successor to the fixed stochastic layer.
- Holds a runtime-writable weight bank; each neuron has its own comparator SNGs; output bitstreams are gated by in_valid.
- A control FSM runs an evaluation window of STREAM_LEN valid input bits, counts ones per neuron, then presents the counts through a valid/ready result port.
- Sits between consecutive layers, or between the last layer and the classifier readout.

Parameters:
INPUT_SIZE, 2, bitstream inputs per neuron
NEURON_COUNT, 2, neurons in layer
WEIGHT_W, 8, weight width (must be <= 16)
STREAM_LEN, 256, valid bits per evaluation window (>= 1)
SEED, 0, base LFSR seed
CNT_W, $clog2(STREAM_LEN+1), count width per neuron (derived)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
cfg_we  in  1  weight write strobe
cfg_neuron  in  $clog2(NEURON_COUNT) (min 1)  target neuron
cfg_input  in  $clog2(INPUT_SIZE) (min 1)  target input
cfg_weight  in  WEIGHT_W  weight value
start  in  1  begin evaluation window
busy  out  1  FSM not IDLE
layer_input  in  INPUT_SIZE  input bitstream bits
in_valid  in  1  layer_input valid this cycle
stream_out  out  NEURON_COUNT  registered neuron bits (feeds next layer)
stream_valid  out  1  stream_out valid
result_data  out  NEURON_COUNT*CNT_W  per-neuron counts; neuron i at [i*CNT_W +: CNT_W]
result_valid  out  1  counts valid
result_ready  in  1  consumer accepts counts

Behaviour:
- Reset (async, n_rst=0): FSM IDLE; all weights 0; counters 0; remaining=0; LFSRs loaded with seeds; all outputs 0.
- LFSR per (neuron i, input j):
  - 16-bit Galois, shift right; if lsb=1, XOR with 16'hB400.
  - Seed = (SEED + i*INPUT_SIZE + j + 1) mod 2^16; a zero seed is replaced by 16'h0001.
- Weight bit w[i][j]:
  - 1 if weight is all-ones (represents 1.0).
  - Otherwise 1 if lfsr[WEIGHT_W-1:0] < weight.
  - Weight 0 gives a constant 0.
- Neuron bit n[i] = OR over j of (layer_input[j] AND w[i][j]).
- Weight writes: accepted only in IDLE, taking effect the next cycle. Ignored in RUN/HOLD. Out-of-range cfg_neuron/cfg_input writes are ignored.
- FSM states:
  - IDLE: start=1 -> RUN. On this transition: counters cleared, remaining=STREAM_LEN, all LFSRs reloaded with seeds.
  - RUN, cycle with in_valid=1:
    - Compute n[] from current LFSR values, then advance all LFSRs.
    - Register n[] into stream_out with stream_valid=1 the next cycle (latency 1).
    - counter[i] += n[i]; remaining--.
    - If remaining was 1 -> HOLD.
  - RUN, cycle with in_valid=0: LFSRs, counters, remaining held; stream_valid=0 next cycle.
  - HOLD: result_valid=1 and result_data=counters, held stable while result_ready=0. When result_valid&&result_ready -> IDLE and result_valid=0 the next cycle.
- start is ignored outside IDLE. busy=1 in RUN and HOLD.
- First result_valid appears exactly one cycle after the last valid input bit is accepted.
- Counters cannot overflow: maximum value is STREAM_LEN, which fits CNT_W.
- start and cfg_we in the same IDLE cycle: both take effect. The write lands before the first RUN cycle.
- Reset mid-RUN/HOLD: immediate abort to the reset state; weights are cleared.
- stream_out retains its last value when stream_valid=0.

Test Plan:
1. All weights written to 8'hFF, layer_input all 1, in_valid=1 every cycle, STREAM_LEN=256 -> every count = 256; result_valid asserts 257 cycles after start.
2. All weights 0, inputs all 1 -> all counts 0; stream_out stays 0 throughout the window.
3. Neuron 0 weights 8'hFF, neuron 1 weights 0, in_valid toggled 1/0 -> counts {0, 256}; window lasts 512 cycles; stream_valid mirrors in_valid delayed by 1.
4. Mid weights (8'h80), random inputs -> counts match a bit-exact reference model of the LFSR/compare/OR rule. Rerun with identical stimulus -> identical counts, since LFSRs reload on start.
5. HOLD with result_ready=0 for 20 cycles, while start and cfg_we are pulsed -> result_data stable, no new window starts, weights unchanged. result_ready=1 -> IDLE the next cycle.
6. Assert n_rst=0 at window cycle 100 -> busy=0, result_valid=0, stream_valid=0 immediately. After release, start with no writes -> all counts 0.
